// File: rtl/combo_chk_pkg.sv
// combo_chk_pkg: shared states, MISR constants and default width for combo_resp_checker
package combo_chk_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  localparam int N_IN_DEF = 5;
endpackage

// File: rtl/combo_chk_misr.sv
// combo_chk_misr: 16-bit single-input MISR (x^16+x^12+x^5+1), seeded on reset and clr
module combo_chk_misr
  import combo_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= MISR_SEED;
    else if (clr) sig <= MISR_SEED;
    else if (en) sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ din) ? MISR_POLY : 16'h0000);
endmodule

// File: rtl/combo_resp_checker.sv
// combo_resp_checker: captures combo truth table, tracks coverage/mismatches; COMBO_CHK_MISR_EN adds misr_sig
module combo_resp_checker
  import combo_chk_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter logic [2**N_IN-1:0] EXP_TT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               smp_valid,
  input  logic [N_IN-1:0]    smp_vec,
  input  logic               smp_z,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2**N_IN-1:0] resp_tt,
  output logic [2**N_IN-1:0] cov_mask,
  output logic [N_IN:0]      err_cnt,
  output logic               err_flag,
  output logic [N_IN-1:0]    first_err
`ifdef COMBO_CHK_MISR_EN
  , output logic [15:0]      misr_sig
`endif
);
  localparam int TW = 2**N_IN;
  localparam logic [N_IN:0] ERR_MAX = (N_IN+1)'(TW);
  state_t state, state_nx;
  logic accept, mism;
  logic [TW-1:0] cov_nx;
  // start takes priority, so a colliding sample is never accepted
  assign accept = (state == CAPTURE) && smp_valid && !start;
  assign cov_nx = cov_mask | (TW'(1) << smp_vec);
  assign mism = smp_z != EXP_TT[smp_vec];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = start ? CAPTURE : (accept && &cov_nx) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_tt   <= '0;
      cov_mask  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
    end else if (start) begin
      resp_tt   <= '0;
      cov_mask  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
    end else if (accept) begin
      resp_tt[smp_vec] <= smp_z;
      cov_mask         <= cov_nx;
      if (mism) begin
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0) first_err <= smp_vec;
      end
    end
  assign busy     = state == CAPTURE;
  assign done     = state == DONE;
  assign err_flag = err_cnt != '0;
  assign pass     = done && !err_flag;
`ifdef COMBO_CHK_MISR_EN
  combo_chk_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (accept),
    .din   (smp_z),
    .sig   (misr_sig)
  );
`endif
endmodule

// File: tb/tb_combo_resp_checker.sv
// tb_combo_resp_checker: directed checkpoints queued by stimulus, compared by a negedge monitor
module tb_combo_resp_checker;
  typedef struct packed {
    logic        busy, done, pass, ef;
    logic [5:0]  cnt;
    logic [4:0]  fe;
    logic [31:0] cov, resp;
  } exp_t;
  logic clk = 1'b0, rst_n, start, smp_valid, smp_z;
  logic [4:0] smp_vec;
  logic busy, done, pass, err_flag;
  logic [31:0] resp_tt, cov_mask;
  logic [5:0] err_cnt;
  logic [4:0] first_err;
  int total = 0, bad = 0;
  exp_t q[$];
  string nq[$];
`ifdef COMBO_CHK_MISR_EN
  logic [15:0] misr_sig;
`endif
  always #5 clk = ~clk;
  combo_resp_checker #(.N_IN(5), .EXP_TT(32'h8000_0001)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .smp_vec(smp_vec), .smp_z(smp_z), .busy(busy), .done(done), .pass(pass),
    .resp_tt(resp_tt), .cov_mask(cov_mask), .err_cnt(err_cnt),
    .err_flag(err_flag), .first_err(first_err)
`ifdef COMBO_CHK_MISR_EN
    , .misr_sig(misr_sig)
`endif
  );
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e, a;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      a = '{busy, done, pass, err_flag, err_cnt, first_err, cov_mask, resp_tt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got busy=%b done=%b pass=%b ef=%b cnt=%0d fe=%0d cov=%h resp=%h, want busy=%b done=%b pass=%b ef=%b cnt=%0d fe=%0d cov=%h resp=%h",
                 n, a.busy, a.done, a.pass, a.ef, a.cnt, a.fe, a.cov, a.resp,
                 e.busy, e.done, e.pass, e.ef, e.cnt, e.fe, e.cov, e.resp);
      end
    end
  task automatic chk(input string n, input logic b, d, p, ef, input logic [5:0] c,
                     input logic [4:0] fe, input logic [31:0] cov, resp);
    q.push_back('{b, d, p, ef, c, fe, cov, resp});
    nq.push_back(n);
  endtask
  task automatic smp(input logic [4:0] v, input logic z);
    smp_valid = 1'b1; smp_vec = v; smp_z = z;
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
`ifdef COMBO_CHK_MISR_EN
  function automatic logic [15:0] misr_ref(input int n);
    logic [15:0] s = 16'hFFFF;
    for (int i = 0; i < n; i++) s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0);
    return s;
  endfunction
  task automatic chk_misr(input string n, input logic [15:0] want);
    total++;
    if (misr_sig !== want) begin
      bad++;
      $display("FAIL %s: got misr=%h want %h", n, misr_sig, want);
    end
  endtask
`endif
  initial begin
    rst_n = 1'b0; start = 1'b0; smp_valid = 1'b0; smp_vec = '0; smp_z = 1'b0;
    chk("reset", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    smp(3, 1); smp(7, 0);
    chk("idle_ignore", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    go();
    chk("start", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int v = 0; v < 32; v++) begin
      smp(5'(v), v == 0 || v == 31);
      if (v == 30) chk("sweep30", 1, 0, 0, 0, 0, 0, 32'h7FFF_FFFF, 32'h0000_0001);
    end
    chk("clean_done", 0, 1, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h8000_0001);
    smp(5, 1);
    chk("done_ignore", 0, 1, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h8000_0001);
    go();
    chk("restart", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int v = 0; v < 32; v++) begin
      smp(5'(v), (v == 0 || v == 31) ^ (v == 5 || v == 20));
      if (v == 5) chk("first_mism", 1, 0, 0, 1, 1, 5, 32'h0000_003F, 32'h0000_0021);
    end
    chk("mism_done", 0, 1, 0, 1, 2, 5, 32'hFFFF_FFFF, 32'h8010_0021);
    go();
    for (int v = 0; v < 31; v++) smp(5'(v), v == 0);
    smp(3, 0);
    chk("dup_gap", 1, 0, 0, 0, 0, 0, 32'h7FFF_FFFF, 32'h0000_0001);
    smp(3, 1); smp(3, 1);
    chk("dup_mism", 1, 0, 0, 1, 2, 3, 32'h7FFF_FFFF, 32'h0000_0009);
    smp(31, 1);
    chk("gap_fill", 0, 1, 0, 1, 2, 3, 32'hFFFF_FFFF, 32'h8000_0009);
    go();
    smp(0, 1); smp(1, 0); smp(2, 1);
    chk("pre_collide", 1, 0, 0, 1, 1, 2, 32'h0000_0007, 32'h0000_0005);
    start = 1'b1; smp_valid = 1'b1; smp_vec = 5'd9; smp_z = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; smp_valid = 1'b0;
    chk("collide", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    smp(9, 0);
    chk("post_collide", 1, 0, 0, 0, 0, 0, 32'h0000_0200, 32'h0);
    repeat (34) smp(0, 0);
    chk("saturate", 1, 0, 0, 1, 32, 0, 32'h0000_0201, 32'h0);
    smp(4, 1);
    rst_n = 1'b0;
    chk("async_rst", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    smp(6, 0); smp(7, 1);
    chk("post_rst_idle", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
`ifdef COMBO_CHK_MISR_EN
    go();
    for (int v = 0; v < 32; v++) smp(5'(v), 1'b0);
    chk_misr("misr_sweep", misr_ref(32));
    smp(1, 1);
    chk_misr("misr_frozen", misr_ref(32));
    go();
    chk_misr("misr_reload", 16'hFFFF);
`endif
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending checks, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
